// File: rtl/inst_mem_loader_if.sv
// ---------------------------------------------------------------------------
// inst_mem_loader_if
//   Bundles the byte-stream input, the instruction-memory write port and the
//   session status of the instruction memory loader.
//
//   master : the loader. It takes start and the byte stream, and drives
//            rx_ready, the write port and the status flags.
//   slave  : the environment. It is the byte source, the memory and the
//            core-side controller together.
//
//   Signals
//     start          begin a load session
//     rx_data/valid  incoming byte and its qualifier
//     rx_ready       loader can accept a byte this cycle
//     write_address  word address into instruction memory
//     op_code        16-bit instruction word to write
//     write_enable   one-cycle write strobe
//     busy/done/error  session status (done/error are sticky)
// ---------------------------------------------------------------------------
interface inst_mem_loader_if #(
    parameter int ADDR_W = 32
) ();
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] write_address;
    logic [15:0]       op_code;
    logic              write_enable;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        input  start, rx_data, rx_valid,
        output rx_ready, write_address, op_code, write_enable, busy, done, error
    );

    modport slave (
        output start, rx_data, rx_valid,
        input  rx_ready, write_address, op_code, write_enable, busy, done, error
    );
endinterface

// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
//   Writer side of the instruction memory's load port. Takes a program as a
//   byte stream (LEN_HI, LEN_LO, then N words as HI, LO) and writes each
//   16-bit word to instruction memory, one write_enable pulse per word,
//   starting at BASE_ADDR. busy is high for the whole session so the core
//   can be held off; done/error are sticky until the next start.
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    inst_mem_loader_if.master (byte stream, write port, status)
//
//   Parameters
//     ADDR_W     width of write_address
//     BASE_ADDR  word address of the first instruction written
//     MAX_WORDS  largest accepted program length; longer -> error
//     TIMEOUT    max idle cycles between accepted bytes; 0 disables it
// ---------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_WORDS = 65535,
    parameter int unsigned       TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    inst_mem_loader_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_WRITE, S_DONE, S_ERR
    } state_t;

    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    state_t      state;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [7:0]  hi_byte;
    logic [15:0] idx;
    logic [31:0] tcount;

    logic        accept;
    logic        timed_out;
    logic [15:0] rx_len;

    assign accept    = bus.rx_valid && bus.rx_ready;
    assign timed_out = (TIMEOUT != 0) && (tcount == TO_LAST);
    assign rx_len    = {len_hi, bus.rx_data};

    // rx_ready and busy are registered, so every transition also sets the
    // values they must have in the state being entered.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; the reset branch is synchronous.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            len_hi            <= '0;
            len               <= '0;
            hi_byte           <= '0;
            idx               <= '0;
            tcount            <= '0;
            bus.rx_ready      <= 1'b0;
            bus.write_address <= '0;
            bus.op_code       <= '0;
            bus.write_enable  <= 1'b0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.error         <= 1'b0;
        end else begin
            bus.write_enable <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        state        <= S_LEN_HI;
                        idx          <= '0;
                        tcount       <= '0;
                        bus.rx_ready <= 1'b1;
                        bus.busy     <= 1'b1;
                        bus.done     <= 1'b0;
                        bus.error    <= 1'b0;
                    end
                end

                S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO: begin
                    if (accept) begin
                        tcount <= '0;
                        case (state)
                            S_LEN_HI: begin
                                len_hi <= bus.rx_data;
                                state  <= S_LEN_LO;
                            end
                            S_LEN_LO: begin
                                len <= rx_len;
                                if (rx_len == 16'd0) begin
                                    state        <= S_DONE;
                                    bus.done     <= 1'b1;
                                    bus.rx_ready <= 1'b0;
                                    bus.busy     <= 1'b0;
                                end else if (32'(rx_len) > MAX_WORDS) begin
                                    state        <= S_ERR;
                                    bus.error    <= 1'b1;
                                    bus.rx_ready <= 1'b0;
                                    bus.busy     <= 1'b0;
                                end else begin
                                    state <= S_DAT_HI;
                                end
                            end
                            S_DAT_HI: begin
                                hi_byte <= bus.rx_data;
                                state   <= S_DAT_LO;
                            end
                            default: begin  // S_DAT_LO: issue the write next cycle
                                state             <= S_WRITE;
                                bus.rx_ready      <= 1'b0;
                                bus.write_enable  <= 1'b1;
                                bus.op_code       <= {hi_byte, bus.rx_data};
                                bus.write_address <= BASE_ADDR + ADDR_W'(idx);
                            end
                        endcase
                    end else if (timed_out) begin
                        state        <= S_ERR;
                        tcount       <= '0;
                        bus.error    <= 1'b1;
                        bus.rx_ready <= 1'b0;
                        bus.busy     <= 1'b0;
                    end else if (TIMEOUT != 0) begin
                        tcount <= tcount + 32'd1;
                    end
                end

                S_WRITE: begin
                    // The write strobe is already out; decide whether it was the last word.
                    if ({1'b0, idx} + 17'd1 == {1'b0, len}) begin
                        state    <= S_DONE;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end else begin
                        idx          <= idx + 16'd1;
                        state        <= S_DAT_HI;
                        bus.rx_ready <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
